// File: rtl/spi_slave_rx_pkg.sv
// spi_slave_rx_pkg: state type, pointer-width helper and reset constants for spi_slave_rx
package spi_slave_rx_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} t_spi_rx_state;
    localparam logic RST_CS_N = 1'b1;
    localparam logic RST_SCLK = 1'b0;
    localparam logic [7:0] OVR_CNT_MAX = 8'hFF;
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/spi_rx_sync.sv
// spi_rx_sync: parametrized-width two-flop synchronizer with synchronous reset to RST_VAL
module spi_rx_sync #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end
    assign q_o = s2_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: multi-lane SPI slave deserializer feeding a show-ahead FIFO.
// Define SPI_SLAVE_RX_OVR_CNT_EN to enable the saturating overrun counter on o_ovr_cnt.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int G_SPI_SIZE   = 4,
    parameter int G_DATA_WIDTH = 8,
    parameter int G_FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                spi_slave_clk,
    input  logic                                spi_slave_cs_n,
    input  logic [G_SPI_SIZE-1:0]               spi_slave_di,
    output logic [G_DATA_WIDTH-1:0]             o_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [ptr_width(G_FIFO_DEPTH)-1:0]  o_level,
    output logic                                o_overrun,
    output logic                                o_frame_err,
    output logic [7:0]                          o_ovr_cnt
);
    localparam int PW = ptr_width(G_FIFO_DEPTH);
    localparam int BEATS = G_DATA_WIDTH / G_SPI_SIZE;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic sclk_s, cs_s;
    logic [G_SPI_SIZE-1:0] di_s;
    spi_rx_sync #(.W(1), .RST_VAL(RST_SCLK)) u_sync_sclk (.clk, .rst, .d_i(spi_slave_clk), .q_o(sclk_s));
    spi_rx_sync #(.W(1), .RST_VAL(RST_CS_N)) u_sync_cs (.clk, .rst, .d_i(spi_slave_cs_n), .q_o(cs_s));
    spi_rx_sync #(.W(G_SPI_SIZE), .RST_VAL('0)) u_sync_di (.clk, .rst, .d_i(spi_slave_di), .q_o(di_s));

    logic sclk_prev_q, edge_q, armed_q, word_done_q, word_done_d, frame_err_q, frame_err_d, overrun_q;
    logic [1:0] settle_q;
    t_spi_rx_state state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [G_DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic [G_DATA_WIDTH-1:0] mem [G_FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic empty, full, pop, push;

    if (G_DATA_WIDTH > G_SPI_SIZE) begin : g_shift
        assign shifted = {shreg_q[G_DATA_WIDTH-G_SPI_SIZE-1:0], di_s};
    end else begin : g_single
        assign shifted = di_s;
    end

    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        shreg_d = shreg_q;
        word_done_d = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == IDLE) begin
            beat_d = '0;
            shreg_d = '0;
            state_d = (!cs_s && armed_q) ? SHIFT : IDLE;
        end else if (cs_s) begin
            state_d = IDLE;
            frame_err_d = beat_q != '0;
            beat_d = '0;
            shreg_d = '0;
        end else if (edge_q) begin
            shreg_d = shifted;
            beat_d = (beat_q == LAST) ? '0 : beat_q + BW'(1);
            word_done_d = beat_q == LAST;
        end
    end

    // armed_q ignores the reset-value cs_n until the synchronizer carries the real pin level
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            edge_q <= 1'b0;
            settle_q <= 2'd0;
            armed_q <= 1'b0;
            state_q <= IDLE;
            beat_q <= '0;
            shreg_q <= '0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            edge_q <= sclk_s && !sclk_prev_q;
            settle_q <= settle_q[1] ? settle_q : settle_q + 2'd1;
            armed_q <= armed_q || (cs_s && settle_q[1]);
            state_q <= state_d;
            beat_q <= beat_d;
            shreg_q <= shreg_d;
            word_done_q <= word_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign empty = wr_q == rd_q;
    assign full = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
    assign pop = i_ready && !empty;
    assign push = word_done_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PW-2:0]] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q <= wr_q + PW'(push);
            rd_q <= rd_q + PW'(pop);
            overrun_q <= word_done_q && full && !pop;
        end
    end

    assign o_valid = !empty;
    assign o_data = empty ? '0 : mem[rd_q[PW-2:0]];
    assign o_level = wr_q - rd_q;
    assign o_overrun = overrun_q;
    assign o_frame_err = frame_err_q;

`ifdef SPI_SLAVE_RX_OVR_CNT_EN
    logic [7:0] ovr_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) ovr_cnt_q <= 8'd0;
        else if (overrun_q && ovr_cnt_q != OVR_CNT_MAX) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
    assign o_ovr_cnt = ovr_cnt_q;
`else
    assign o_ovr_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: table-driven frames plus hand-written corner sequences with a word scoreboard
`timescale 1ns/100ps
module tb_spi_slave_rx;
    localparam int LW = 6;
`ifdef SPI_SLAVE_RX_OVR_CNT_EN
    localparam int EXP_OVR = 1;
`else
    localparam int EXP_OVR = 0;
`endif

    logic clk = 0, rst = 1, sclk = 0, cs = 1, i_ready = 0, use_dly = 0;
    logic [3:0] di = 0;
    logic [7:0] o_data, o_ovr_cnt;
    logic o_valid, o_overrun, o_frame_err;
    logic [3:0] o_level;
    logic [LW-1:0] line_now, pipe [100];
    logic d_sclk, d_cs;
    logic [3:0] d_di;

    int errors = 0, checks = 0;
    int ovr_n = 0, fe_n = 0, wide_n = 0;
    logic ovr_p = 0, fe_p = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    // transport delay line for the line-delay test, ticking off the clock edges
    assign line_now = {cs, sclk, di};
    initial begin
        #0.5;
        forever begin
            #1;
            for (int i = 99; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = line_now;
        end
    end
    assign d_cs = use_dly ? pipe[99][5] : cs;
    assign d_sclk = use_dly ? pipe[99][4] : sclk;
    assign d_di = use_dly ? pipe[99][3:0] : di;

    spi_slave_rx #(.G_SPI_SIZE(4), .G_DATA_WIDTH(8), .G_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .spi_slave_clk(d_sclk), .spi_slave_cs_n(d_cs), .spi_slave_di(d_di),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level),
        .o_overrun(o_overrun), .o_frame_err(o_frame_err), .o_ovr_cnt(o_ovr_cnt)
    );

    always @(negedge clk) begin
        if (o_overrun && !ovr_p) ovr_n++;
        if (o_frame_err && !fe_p) fe_n++;
        if ((o_overrun && ovr_p) || (o_frame_err && fe_p)) wide_n++;
        ovr_p = o_overrun;
        fe_p = o_frame_err;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nb, input int hp);
        cs = 0;
        cyc(4);
        for (int b = 0; b < nb; b++) begin
            di = bits[4*(nb-1-b) +: 4];
            cyc(hp);
            sclk = 1;
            cyc(hp);
            sclk = 0;
            if (b % 2 == 1 && sb.size() < 8) sb.push_back(bits[4*(nb-1-b) +: 8]);
        end
        cyc(hp);
        cs = 1;
        cyc(16);
    endtask

    task automatic drain(input string nm);
        while (sb.size() > 0) begin
            int t = 0;
            while (!o_valid && t < 60) begin
                cyc(1);
                t++;
            end
            chk({nm, " valid"}, o_valid, 1);
            chk({nm, " data"}, o_data, sb.pop_front());
            i_ready = 1;
            cyc(1);
            i_ready = 0;
        end
        chk({nm, " empty"}, o_valid, 0);
        chk({nm, " level0"}, o_level, 0);
    endtask

    typedef struct {
        logic [31:0] bits;
        int nb;
        int exp_fe;
        int exp_lvl;
    } vec_t;
    vec_t tv [8];

    initial begin
        int fe0, ovr0;
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fe0, ovr0;
        tv[0] = '{32'hA5, 2, 0, 1};
        tv[1] = '{32'h3C, 2, 0, 1};
        tv[2] = '{32'h0FF0, 4, 0, 2};
        tv[3] = '{32'hB, 1, 1, 0};
        tv[4] = '{32'hC3D, 3, 1, 1};
        tv[5] = '{32'hFF00, 4, 0, 2};
        tv[6] = '{32'h123456, 6, 0, 3};
        tv[7] = '{32'h5A69C3E1, 8, 0, 4};

        cyc(3);
        rst = 0;
        cyc(3);
        chk("rst valid", o_valid, 0);
        chk("rst data", o_data, 0);
        chk("rst level", o_level, 0);
        chk("rst overrun", o_overrun, 0);
        chk("rst frame_err", o_frame_err, 0);
        chk("rst ovr_cnt", o_ovr_cnt, 0);
        cyc(4);

        // single word with exact latency: pin rise at n0, o_valid at the 5th falling clk edge after
        cs = 0;
        cyc(4);
        di = 4'hA;
        cyc(3);
        sclk = 1;
        cyc(3);
        sclk = 0;
        di = 4'h5;
        cyc(3);
        sclk = 1;
        cyc(4);
        chk("lat valid early", o_valid, 0);
        cyc(1);
        chk("lat valid", o_valid, 1);
        chk("lat data", o_data, 8'hA5);
        chk("lat level", o_level, 1);
        sclk = 0;
        cyc(3);
        cs = 1;
        cyc(8);
        i_ready = 1;
        cyc(1);
        i_ready = 0;
        chk("lat pop empty", o_valid, 0);
        cyc(4);

        for (int i = 0; i < 8; i++) begin
            fe0 = fe_n;
            send_frame(tv[i].bits, tv[i].nb, 3);
            chk($sformatf("tv%0d frame_err", i), fe_n - fe0, tv[i].exp_fe);
            chk($sformatf("tv%0d level", i), o_level, tv[i].exp_lvl);
            drain($sformatf("tv%0d", i));
        end

        ovr0 = ovr_n;
        for (int w = 1; w <= 8; w++) send_frame(w, 2, 3);
        chk("fill no overrun", ovr_n - ovr0, 0);
        chk("fill level", o_level, 8);
        send_frame(9, 2, 3);
        chk("fill overrun", ovr_n - ovr0, 1);
        chk("fill level kept", o_level, 8);
        chk("fill ovr_cnt", o_ovr_cnt, EXP_OVR);
        drain("fill");

        // full FIFO, pop coincides with the push of word 0x19
        for (int w = 8'h11; w <= 8'h18; w++) send_frame(w, 2, 3);
        ovr0 = ovr_n;
        cs = 0;
        cyc(4);
        di = 4'h1;
        cyc(3);
        sclk = 1;
        cyc(3);
        sclk = 0;
        di = 4'h9;
        cyc(3);
        sclk = 1;
        cyc(4);
        chk("pp head", o_data, sb[0]);
        i_ready = 1;
        cyc(1);
        i_ready = 0;
        sclk = 0;
        chk("pp level", o_level, 8);
        void'(sb.pop_front());
        sb.push_back(8'h19);
        cyc(3);
        cs = 1;
        cyc(16);
        chk("pp no overrun", ovr_n - ovr0, 0);
        drain("pp");

        send_frame(32'h55, 2, 3);
        fe0 = fe_n;
        cs = 0;
        cyc(4);
        di = 4'h7;
        cyc(3);
        sclk = 1;
        cyc(3);
        sclk = 0;
        rst = 1;
        cyc(2);
        rst = 0;
        sb.delete();
        cyc(3);
        chk("mrst valid", o_valid, 0);
        chk("mrst data", o_data, 0);
        chk("mrst level", o_level, 0);
        chk("mrst ovr_cnt", o_ovr_cnt, 0);
        di = 4'hE;
        cyc(3);
        sclk = 1;
        cyc(3);
        sclk = 0;
        cyc(3);
        cs = 1;
        cyc(16);
        chk("mrst ignored", o_level, 0);
        chk("mrst no frame_err", fe_n - fe0, 0);
        send_frame(32'h7E, 2, 3);
        drain("mrst next");

        fe0 = fe_n;
        ovr0 = ovr_n;
        use_dly = 1;
        for (int k = 0; k < 16; k++) begin
            send_frame($urandom_range(0, 255), 2, 4);
            if (k % 4 == 3) drain($sformatf("dly%0d", k));
        end
        chk("dly frame_err", fe_n - fe0, 0);
        chk("dly overrun", ovr_n - ovr0, 0);
        chk("pulse width", wide_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
